// File: rtl/rst_sequencer_if.sv
// Board reset sequencer bundle: lock inputs, software re-sequence request,
// staged active-low domain resets and debug status.
//
// Signalling: there is no valid/ready handshake on this bundle. lock_i is
// level-sensitive and asynchronous to the sequencer clock. sw_rst_req_i is a
// synchronous request, sampled on every rising clock edge; a single-cycle
// pulse is enough, and holding it high keeps re-arming the hold phase.
// rst_no, done_o and state_o are registered levels.
interface rst_sequencer_if #(
  parameter int NumDomains = 3,
  parameter int NumLocks   = 2
) ();

  logic [NumLocks-1:0]   lock_i;
  logic                  sw_rst_req_i;
  logic [NumDomains-1:0] rst_no;
  logic                  done_o;
  logic [1:0]            state_o;

  // Sequencer side.
  modport master (
    input  lock_i,
    input  sw_rst_req_i,
    output rst_no,
    output done_o,
    output state_o
  );

  // Board / testbench side.
  modport slave (
    output lock_i,
    output sw_rst_req_i,
    input  rst_no,
    input  done_o,
    input  state_o
  );

endinterface

// File: rtl/rst_sequencer.sv
// Board-level reset sequencer.
//
// Waits for every PLL/MMCM/MIG lock flag to be high, holds every domain in
// reset for HoldCycles, then releases the active-low domain resets one at a
// time, StageGap cycles apart, starting at bit 0 (thermometer pattern).
// Losing lock at any point after WAIT_LOCK drops every reset and starts again
// from WAIT_LOCK. A software request in HOLD, RELEASE or RUN drops every reset
// and restarts the hold phase; it is ignored while waiting for lock.
// Lock loss wins over a software request and over a release on the same edge.
//
// Every output is taken straight from a flop so the reset lines cannot glitch.
module rst_sequencer #(
  parameter int NumDomains = 3,
  parameter int NumLocks   = 2,
  parameter int HoldCycles = 64,
  parameter int StageGap   = 16,
  parameter int SyncStages = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rst_sequencer_if.master bus
);

  // Counter is shared by the hold and stage-gap phases, so it is sized for
  // the longer of the two.
  localparam int MaxCount = (HoldCycles > StageGap) ? HoldCycles : StageGap;
  localparam int CntW     = $clog2(MaxCount + 1);
  localparam int IdxW     = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(StageGap - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumDomains - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Lock synchroniser
  // --------------------------------------------------------------------------
  logic [NumLocks-1:0] sync_q [SyncStages];
  logic                locked;

  // Bring every lock flag into the clk_i domain through a SyncStages-deep chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= bus.lock_i;
      for (int s = 1; s < SyncStages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Only proceed once every clock source reports lock.
  assign locked = &sync_q[SyncStages-1];

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q,   cnt_d;
  logic [IdxW-1:0]       idx_q,   idx_d;
  logic [NumDomains-1:0] rst_no_q, rst_no_d;
  logic                  done_q,  done_d;

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_no_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rst_no_q <= rst_no_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output decode; lock loss is checked first so it
  // overrides both the software request and any release due on this edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rst_no_d = rst_no_q;
    done_d   = done_q;

    if ((state_q != WAIT_LOCK) && !locked) begin
      state_d  = WAIT_LOCK;
      cnt_d    = '0;
      idx_d    = '0;
      rst_no_d = '0;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          rst_no_d = '0;
          done_d   = 1'b0;
          if (locked) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end

        HOLD: begin
          if (bus.sw_rst_req_i) begin
            // Restart the hold count; nothing has been released yet.
            cnt_d = '0;
            idx_d = '0;
          end else if (cnt_q == HoldLast) begin
            rst_no_d[0] = 1'b1;
            cnt_d       = '0;
            idx_d       = IdxW'(1);
            if (NumDomains == 1) begin
              done_d  = 1'b1;
              state_d = RUN;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        RELEASE: begin
          if (bus.sw_rst_req_i) begin
            state_d  = HOLD;
            cnt_d    = '0;
            idx_d    = '0;
            rst_no_d = '0;
            done_d   = 1'b0;
          end else if (cnt_q == GapLast) begin
            cnt_d = '0;
            // Release the domain selected by the index; lower bits are
            // already high, so the pattern stays a thermometer.
            for (int d = 0; d < NumDomains; d++) begin
              if (idx_q == IdxW'(d)) begin
                rst_no_d[d] = 1'b1;
              end
            end
            if (idx_q == LastIdx) begin
              done_d  = 1'b1;
              state_d = RUN;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        RUN: begin
          if (bus.sw_rst_req_i) begin
            state_d  = HOLD;
            cnt_d    = '0;
            idx_d    = '0;
            rst_no_d = '0;
            done_d   = 1'b0;
          end
        end

        default: begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          idx_d    = '0;
          rst_no_d = '0;
          done_d   = 1'b0;
        end
      endcase
    end
  end

  // Outputs are flop outputs with nothing in between.
  assign bus.rst_no  = rst_no_q;
  assign bus.done_o  = done_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: a default-parameter instance (3 domains,
// hold 64, gap 16) and a minimal instance (1 domain, hold 1, gap 1).
// Expected edge numbers and values are queued before each step and popped as
// the DUT responds.
module tb_rst_sequencer;

  localparam int ND = 3;
  localparam int NL = 2;
  localparam int HC = 64;
  localparam int SG = 16;
  localparam int SS = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Free-running edge count; sampled on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  rst_sequencer_if #(.NumDomains(ND), .NumLocks(NL)) bus_a ();
  rst_sequencer_if #(.NumDomains(1),  .NumLocks(NL)) bus_b ();

  rst_sequencer #(
    .NumDomains(ND), .NumLocks(NL), .HoldCycles(HC), .StageGap(SG), .SyncStages(SS)
  ) dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (bus_a)
  );

  rst_sequencer #(
    .NumDomains(1), .NumLocks(NL), .HoldCycles(1), .StageGap(1), .SyncStages(SS)
  ) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_b)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed=%0d, no expected entry queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  // sel < domains: one rst_no bit; 7: whole rst_no; 8: done_o; 9: state_o.
  function automatic int obs(input int d, input int sel);
    int r;
    r = 0;
    if (d == 0) begin
      if (sel == 7)      r = int'(bus_a.rst_no);
      else if (sel == 8) r = int'(bus_a.done_o);
      else if (sel == 9) r = int'(bus_a.state_o);
      else               r = int'(bus_a.rst_no[sel]);
    end else begin
      if (sel == 7)      r = int'(bus_b.rst_no);
      else if (sel == 8) r = int'(bus_b.done_o);
      else if (sel == 9) r = int'(bus_b.state_o);
      else               r = int'(bus_b.rst_no[0]);
    end
    return r;
  endfunction

  // Poll on falling edges until the selected output equals val; rel is the
  // edge number relative to base, or -1 if the budget runs out.
  task automatic wait_for(input int d, input int sel, input int val,
                          input int budget, input int base, output int rel);
    bit hit;
    hit = 1'b0;
    rel = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      if (obs(d, sel) == val) begin
        hit = 1'b1;
        rel = cyc - base;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int base;
    int rec;
    int rel;
    bit quiet;

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.lock_i = 2'b11;
    bus_a.sw_rst_req_i = 1'b0;
    bus_b.lock_i = 2'b11;
    bus_b.sw_rst_req_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    expect_val(0); expect_val(0); expect_val(0);
    check("a_reset_rst_no", obs(0, 7));
    check("a_reset_done",   obs(0, 8));
    check("a_reset_state",  obs(0, 9));
    expect_val(0); expect_val(0); expect_val(0);
    check("b_reset_rst_no", obs(1, 7));
    check("b_reset_done",   obs(1, 8));
    check("b_reset_state",  obs(1, 9));

    // Locks already high when reset falls: HOLD at 3, releases at 67/83/99.
    rst_a = 1'b0;
    base  = cyc;
    expect_val(3);
    expect_val(67); expect_val(2); expect_val(3'b001);
    expect_val(83); expect_val(3'b011);
    expect_val(99); expect_val(1); expect_val(3); expect_val(3'b111);
    wait_for(0, 9, 1, 20, base, rel);  check("s1_hold_edge", rel);
    wait_for(0, 0, 1, 200, base, rel); check("s1_rst0_edge", rel);
    check("s1_release_state", obs(0, 9));
    check("s1_vec_001", obs(0, 7));
    wait_for(0, 1, 1, 200, base, rel); check("s1_rst1_edge", rel);
    check("s1_vec_011", obs(0, 7));
    wait_for(0, 2, 1, 200, base, rel); check("s1_rst2_edge", rel);
    check("s1_done", obs(0, 8));
    check("s1_run_state", obs(0, 9));
    check("s1_vec_111", obs(0, 7));

    // One lock missing for 200 cycles, then both locks present.
    rst_a = 1'b1;
    bus_a.lock_i = 2'b01;
    @(negedge clk);
    rst_a = 1'b0;
    base  = cyc;
    quiet = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (obs(0, 7) != 0 || obs(0, 9) != 0) quiet = 1'b0;
    end
    expect_val(1);
    check("s2_quiet_without_lock", 32'(quiet));
    bus_a.lock_i = 2'b11;
    base = cyc;
    expect_val(67); expect_val(99); expect_val(1);
    wait_for(0, 0, 1, 200, base, rel); check("s2_rst0_edge", rel);
    wait_for(0, 2, 1, 200, base, rel); check("s2_rst2_edge", rel);
    check("s2_done", obs(0, 8));

    // One-cycle lock glitch in RUN.
    bus_a.lock_i = 2'b10;
    base = cyc;
    @(negedge clk);
    bus_a.lock_i = 2'b11;
    rec = cyc;
    expect_val(3); expect_val(0); expect_val(0);
    wait_for(0, 7, 0, 10, base, rel); check("s3_loss_edge", rel);
    check("s3_done_low", obs(0, 8));
    check("s3_state_wait", obs(0, 9));
    expect_val(67); expect_val(99);
    wait_for(0, 0, 1, 200, rec, rel); check("s3_rst0_edge", rel);
    wait_for(0, 2, 1, 200, rec, rel); check("s3_rst2_edge", rel);

    // Software request in RUN, then again in RELEASE with rst_no = 001.
    bus_a.sw_rst_req_i = 1'b1;
    base = cyc;
    @(negedge clk);
    bus_a.sw_rst_req_i = 1'b0;
    expect_val(0); expect_val(1); expect_val(65); expect_val(3'b001);
    check("s4_run_req_vec", obs(0, 7));
    check("s4_run_req_state", obs(0, 9));
    wait_for(0, 0, 1, 200, base, rel); check("s4_run_req_rst0_edge", rel);
    check("s4_release_vec", obs(0, 7));
    bus_a.sw_rst_req_i = 1'b1;
    base = cyc;
    @(negedge clk);
    bus_a.sw_rst_req_i = 1'b0;
    expect_val(0); expect_val(1); expect_val(65); expect_val(2);
    check("s4_rel_req_vec", obs(0, 7));
    check("s4_rel_req_state", obs(0, 9));
    wait_for(0, 0, 1, 200, base, rel); check("s4_rel_req_rst0_edge", rel);
    check("s4_rel_req_state_release", obs(0, 9));

    // Software request on the same edge the synchronised lock falls.
    bus_a.lock_i = 2'b00;
    base = cyc;
    @(negedge clk);
    @(negedge clk);
    expect_val(2);
    check("s5_still_release", obs(0, 9));
    bus_a.sw_rst_req_i = 1'b1;
    @(negedge clk);
    bus_a.sw_rst_req_i = 1'b0;
    expect_val(0); expect_val(0);
    check("s5_lock_wins_state", obs(0, 9));
    check("s5_lock_wins_vec", obs(0, 7));
    bus_a.lock_i = 2'b11;
    base = cyc;
    expect_val(3);
    wait_for(0, 9, 1, 20, base, rel); check("s5_relock_hold_edge", rel);

    // Asynchronous reset mid-HOLD on the default instance.
    @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    expect_val(0); expect_val(0); expect_val(0);
    check("s6_async_state", obs(0, 9));
    check("s6_async_vec", obs(0, 7));
    check("s6_async_done", obs(0, 8));
    @(negedge clk);
    rst_a = 1'b0;

    // Minimal instance: release and done together at edge 4.
    rst_b = 1'b0;
    base  = cyc;
    expect_val(3); expect_val(4); expect_val(1); expect_val(3);
    wait_for(1, 9, 1, 20, base, rel); check("s7_hold_edge", rel);
    wait_for(1, 0, 1, 20, base, rel); check("s7_rst0_edge", rel);
    check("s7_done", obs(1, 8));
    check("s7_run_state", obs(1, 9));

    // Minimal instance: asynchronous reset while in HOLD.
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    base  = cyc;
    expect_val(3);
    wait_for(1, 9, 1, 20, base, rel); check("s7_rehold_edge", rel);
    rst_b = 1'b1;
    #1;
    expect_val(0); expect_val(0); expect_val(0);
    check("s7_async_state", obs(1, 9));
    check("s7_async_vec", obs(1, 7));
    check("s7_async_done", obs(1, 8));
    @(negedge clk);
    expect_val(0);
    check("s7_held_vec", obs(1, 7));
    rst_b = 1'b0;

    if (exp_q.size() != 0) begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d leftover entries, expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
